// File: rtl/batalha_pkg.sv
// batalha_pkg: shared board geometry, validator FSM state encodings and result codes
package batalha_pkg;
  localparam int ROWS = 32;
  localparam int WIDTH = 64;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_GRANT = 3'd1;
  localparam logic [2:0] S_SCAN = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DECIDE = 3'd4;
  localparam logic [2:0] S_WRITE = 3'd5;
  localparam logic [2:0] S_RELEASE = 3'd6;
  localparam logic [2:0] S_FINISH = 3'd7;
  localparam logic [1:0] ERR_OK = 2'd0;
  localparam logic [1:0] ERR_OVERLAP = 2'd1;
  localparam logic [1:0] ERR_LIMIT = 2'd2;
  localparam logic [1:0] ERR_EMPTY = 2'd3;
endpackage

// File: rtl/popcount64.sv
// popcount64: combinational count of set bits in a 64-bit word
module popcount64 (
  input  logic [63:0] i_data,
  output logic [6:0]  o_count
);
  always_comb begin
    o_count = '0;
    for (int i = 0; i < 64; i++) o_count = o_count + 7'(i_data[i]);
  end
endmodule

// File: rtl/validador_tabuleiro.sv
// validador_tabuleiro: scans a player board, checks overlap and cell limit, then writes the new ship row
module validador_tabuleiro
  import batalha_pkg::*;
#(
  parameter int MAX_CELLS = 17,
  parameter int GRANT_WAIT = 2,
  parameter int READ_LAT = 2
) (
  input  logic             clk,
  input  logic             resetGeral,
  input  logic             start,
  input  logic             jogador,
  input  logic [4:0]       linha,
  input  logic [WIDTH-1:0] mascara,
  input  logic [WIDTH-1:0] dataReadValidador,
  output logic             readyValidador,
  output logic             enableValidador,
  output logic             validadorJogador,
  output logic [4:0]       validador_addr,
  output logic [WIDTH-1:0] validador_data,
  output logic             validador_wrep1,
  output logic             validador_wrep2,
  output logic             busy,
  output logic             done,
  output logic             valido,
  output logic [1:0]       erro
);
  logic [2:0]          r_state;
  logic                r_jog;
  logic [4:0]          r_linha;
  logic [WIDTH-1:0]    r_mask;
  logic [WIDTH-1:0]    r_row;
  logic [11:0]         r_acc;
  logic [7:0]          r_cnt;
  logic [4:0]          r_scnt;
  logic [READ_LAT-1:0] r_vld;
  logic [1:0]          r_erro;
  logic                r_valido;
  logic [6:0]          w_pc_rd;
  logic [6:0]          w_pc_m;
  logic                w_overlap;
  logic                w_over;
  popcount64 u_pc_rd (.i_data(dataReadValidador), .o_count(w_pc_rd));
  popcount64 u_pc_m (.i_data(r_mask), .o_count(w_pc_m));
  always_comb begin
    w_overlap = |(r_row & r_mask);
    w_over = (r_acc + 12'(w_pc_m)) > 12'(MAX_CELLS);
    busy = r_state != S_IDLE;
    readyValidador = busy && r_state != S_FINISH;
    enableValidador = readyValidador && r_state != S_RELEASE;
    validadorJogador = busy & r_jog;
    validador_addr = r_state == S_SCAN ? r_cnt[4:0] : r_state == S_WRITE ? r_linha : '0;
    validador_data = r_state == S_WRITE ? (r_row | r_mask) : '0;
    validador_wrep1 = r_state == S_WRITE && !r_jog;
    validador_wrep2 = r_state == S_WRITE && r_jog;
    done = r_state == S_FINISH;
    valido = done & r_valido;
    erro = done ? r_erro : '0;
  end
  always_ff @(posedge clk) begin
    if (resetGeral) begin
      r_state <= S_IDLE;
      r_jog <= 1'b0;
      r_linha <= '0;
      r_mask <= '0;
      r_row <= '0;
      r_acc <= '0;
      r_cnt <= '0;
      r_scnt <= '0;
      r_vld <= '0;
      r_erro <= '0;
      r_valido <= 1'b0;
    end else begin
      r_vld <= READ_LAT'({r_vld, r_state == S_SCAN});
      if (r_vld[READ_LAT-1]) begin
        r_acc <= r_acc + 12'(w_pc_rd);
        r_scnt <= r_scnt + 5'd1;
        if (r_scnt == r_linha) r_row <= dataReadValidador;
      end
      case (r_state)
        S_IDLE: if (start) begin
          r_jog <= jogador;
          r_linha <= linha;
          r_mask <= mascara;
          r_row <= '0;
          r_acc <= '0;
          r_cnt <= '0;
          r_scnt <= '0;
          r_valido <= 1'b0;
          r_erro <= mascara == '0 ? ERR_EMPTY : ERR_OK;
          r_state <= mascara == '0 ? S_FINISH : S_GRANT;
        end
        S_GRANT: begin
          r_cnt <= r_cnt == 8'(GRANT_WAIT - 1) ? '0 : r_cnt + 8'd1;
          r_state <= r_cnt == 8'(GRANT_WAIT - 1) ? S_SCAN : S_GRANT;
        end
        S_SCAN: begin
          r_cnt <= r_cnt == 8'(ROWS - 1) ? '0 : r_cnt + 8'd1;
          r_state <= r_cnt == 8'(ROWS - 1) ? S_DRAIN : S_SCAN;
        end
        S_DRAIN: begin
          r_cnt <= r_cnt == 8'(READ_LAT - 1) ? '0 : r_cnt + 8'd1;
          r_state <= r_cnt == 8'(READ_LAT - 1) ? S_DECIDE : S_DRAIN;
        end
        S_DECIDE: begin
          r_erro <= w_overlap ? ERR_OVERLAP : w_over ? ERR_LIMIT : ERR_OK;
          r_valido <= !w_overlap && !w_over;
          r_state <= (!w_overlap && !w_over) ? S_WRITE : S_RELEASE;
        end
        S_WRITE: r_state <= S_RELEASE;
        S_RELEASE: r_state <= S_FINISH;
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/validador_tabuleiro.md
VALIDADOR_TABULEIRO -- requirements
Module: validador_tabuleiro

Interface
REQ-001 The block SHALL have parameter MAX_CELLS, default 17, giving the maximum number of occupied ship cells per player board.
REQ-002 The block SHALL have parameter GRANT_WAIT, default 2, giving the cycles from raising readyValidador to the first valid address.
REQ-003 The block SHALL have parameter READ_LAT, default 2, giving the cycles from address presented to dataReadValidador valid.
REQ-004 clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 resetGeral  in  1  reset, synchronous and active-high.
REQ-006 start  in  1  one-cycle request to place a ship segment; sampled only in IDLE.
REQ-007 jogador  in  1  target board: 0 = player 1, 1 = player 2; captured with start.
REQ-008 linha  in  5  target row address; captured with start.
REQ-009 mascara  in  64  cells to occupy in the target row; captured with start.
REQ-010 dataReadValidador  in  64  row read back from the memory controller.
REQ-011 readyValidador  out  1  bus request to the memory controller.
REQ-012 enableValidador  out  1  scan-in-progress qualifier to the controller.
REQ-013 validadorJogador  out  1  board selected; equals captured jogador while busy.
REQ-014 validador_addr  out  5  read/write row address.
REQ-015 validador_data  out  64  write data.
REQ-016 validador_wrep1 / validador_wrep2  out  1 each  write enables for player 1 / player 2 memory.
REQ-017 busy  out  1  high from the cycle after start is accepted until done.
REQ-018 done  out  1  one-cycle completion pulse.
REQ-019 valido  out  1  placement accepted; qualified by done.
REQ-020 erro  out  2  result code: 0 ok, 1 overlap, 2 over limit, 3 empty mask; qualified by done.

Function
REQ-021 The FSM SHALL have states IDLE, GRANT, SCAN, DRAIN, DECIDE, WRITE, RELEASE, FINISH.
REQ-022 IDLE SHALL go to FINISH with erro=3 when start=1 and mascara=0, with no bus request.
REQ-023 IDLE SHALL otherwise go to GRANT on start=1, registering jogador, linha and mascara.
REQ-024 GRANT SHALL hold readyValidador=1 and enableValidador=1 for GRANT_WAIT cycles, then enter SCAN.
REQ-025 SCAN SHALL issue validador_addr 0..31, one per cycle, with both write enables low.
REQ-026 Read data for address a SHALL be sampled exactly READ_LAT cycles after a was issued.
REQ-027 DRAIN SHALL last READ_LAT cycles so that all 32 samples are taken.
REQ-028 Each sample SHALL add popcount(row) to a 12-bit accumulator that is cleared on entry to GRANT.
REQ-029 The sample whose index equals linha SHALL be stored as row_atual.
REQ-030 DECIDE SHALL set erro=1 if (row_atual AND mascara) != 0.
REQ-031 DECIDE SHALL otherwise set erro=2 if accumulator + popcount(mascara) > MAX_CELLS, computed in 12 bits.
REQ-032 DECIDE SHALL otherwise set erro=0, valido=1 and go to WRITE; for erro=1 or erro=2 it SHALL go to RELEASE.
REQ-033 WRITE SHALL last exactly 1 cycle with validador_addr=linha, validador_data=row_atual OR mascara, and validador_wrep1 (jogador=0) or validador_wrep2 (jogador=1) high.
REQ-034 At most one write enable SHALL be high in any cycle.
REQ-035 RELEASE SHALL hold readyValidador=1 and enableValidador=0 for 1 cycle, then go to FINISH.
REQ-036 FINISH SHALL pulse done for 1 cycle with valido and erro valid, then return to IDLE.
REQ-037 Latency from start to done SHALL be 1+GRANT_WAIT+32+READ_LAT+1+1+1+1 cycles when accepted (41 at defaults), one fewer when rejected after scan, and 2 for an empty mask.
REQ-038 start SHALL be ignored while busy=1.
REQ-039 An overlap SHALL take priority over over-limit when both hold.
REQ-040 validador_data SHALL be 0 outside WRITE.

Reset
REQ-041 When resetGeral=1 at a clock edge, the FSM SHALL go to IDLE from any state, including mid-SCAN and WRITE, and SHALL not complete any pending write.
REQ-042 Reset values: all outputs 0, accumulator 0, row_atual 0, captured registers 0.

Structure
REQ-043 State encodings, erro codes and the row count (32) and width (64) constants SHALL reside in the shared package batalha_pkg.
REQ-044 Population count SHALL be one combinational sub-module, popcount64 (64-bit in, 7-bit out), instantiated twice (read sample and mascara).

Verification
REQ-045 Empty board, jogador=0, linha=3, mascara=0x1F -> done at cycle 41, valido=1, erro=0, one wrep1 pulse with addr=3 and data=0x1F, wrep2 never high.
REQ-046 Row 3 = 0x10, mascara=0x30, jogador=1 -> erro=1, valido=0, no write enable.
REQ-047 Board holds 15 cells, mascara=0x7 -> erro=2; with 14 cells, mascara=0x7 -> erro=0, write occurs.
REQ-048 mascara=0 -> done 2 cycles after start, erro=3, readyValidador never high.
REQ-049 resetGeral asserted during SCAN at addr 10 -> next cycle IDLE, all outputs 0, no write; a following start completes normally.
REQ-050 start pulsed again while busy -> ignored; exactly one done pulse.
